// File: rtl/svc_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : svc_scheduler                                                   |
// | Purpose  : Two-class (VIP / normal) customer scheduler with anti-starvation |
// |            aging and round-robin assignment to idle service counters.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module svc_scheduler #(
  parameter int DT_SZ   = 4,
  parameter int CNTER   = 3,
  parameter int AGE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             v_emp,
  input  logic [DT_SZ-1:0] v_num,
  input  logic [DT_SZ-1:0] v_tim,
  output logic             v_re,
  input  logic             n_emp,
  input  logic [DT_SZ-1:0] n_num,
  input  logic [DT_SZ-1:0] n_tim,
  output logic             n_re,
  input  logic [CNTER-1:0] busy,
  output logic [CNTER-1:0] ld,
  output logic [DT_SZ-1:0] dn,
  output logic [DT_SZ-1:0] dt,
  output logic             src,
  output logic [3:0]       age,
  output logic [7:0]       drop_cnt
);

  localparam int         PTR_W     = $clog2(CNTER);
  localparam logic [3:0] c_AGE_SAT = 4'd15;
  localparam logic [3:0] c_AGE_MAX = 4'(AGE_MAX);
  localparam logic [PTR_W:0] c_CNTER = (PTR_W+1)'(CNTER);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_rr_ptr;

  // Counter scan results
  logic             w_found;
  logic [PTR_W-1:0] w_k;
  logic [PTR_W:0]   w_scan;
  logic [PTR_W:0]   w_rr_sum;
  logic [PTR_W-1:0] w_rr_adv;
  logic [CNTER-1:0] w_ld_sel;

  // Source select and head mux
  logic             w_pick_n;
  logic             w_go;
  logic [DT_SZ-1:0] w_head_num;
  logic [DT_SZ-1:0] w_head_tim;
  logic [3:0]       w_age_inc;

  // Next values of the registered outputs
  logic             w_v_re_nxt;
  logic             w_n_re_nxt;
  logic [CNTER-1:0] w_ld_nxt;
  logic [DT_SZ-1:0] w_dn_nxt;
  logic [DT_SZ-1:0] w_dt_nxt;
  logic             w_src_nxt;
  logic [3:0]       w_age_nxt;
  logic [7:0]       w_drop_nxt;
  logic [PTR_W-1:0] w_rr_nxt;

  // Round-robin scan: first idle counter at or after rr_ptr, wrapping modulo CNTER
  always_comb begin
    w_found = 1'b0;
    w_k     = '0;
    w_scan  = '0;
    for (int i = 0; i < CNTER; i++) begin
      w_scan = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
      if (w_scan >= c_CNTER) begin
        w_scan = w_scan - c_CNTER;
      end
      if (!w_found && !busy[w_scan[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_k     = w_scan[PTR_W-1:0];
      end
    end
  end

  // Pointer advance past the chosen counter and its one-hot load strobe
  always_comb begin
    w_rr_sum = {1'b0, w_k} + (PTR_W+1)'(1);
    w_rr_adv = (w_rr_sum == c_CNTER) ? '0 : w_rr_sum[PTR_W-1:0];
    w_ld_sel = CNTER'(1) << w_k;
  end

  // Source choice: normal is forced once VIP has won AGE_MAX times in a row
  // while a normal customer was waiting; otherwise VIP whenever present.
  always_comb begin
    w_pick_n   = v_emp | (!n_emp && (age >= c_AGE_MAX));
    w_head_num = w_pick_n ? n_num : v_num;
    w_head_tim = w_pick_n ? n_tim : v_tim;
    w_age_inc  = (age == c_AGE_SAT) ? age : age + 4'd1;
    w_go       = en & w_found & (!v_emp | !n_emp);
  end

  // Next-state and next-output logic; pulses default low so they last one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_v_re_nxt  = 1'b0;
    w_n_re_nxt  = 1'b0;
    w_ld_nxt    = '0;
    w_dn_nxt    = dn;
    w_dt_nxt    = dt;
    w_src_nxt   = src;
    w_age_nxt   = age;
    w_drop_nxt  = drop_cnt;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_LOAD;
          w_src_nxt   = !w_pick_n;
          w_dn_nxt    = w_head_num;
          w_dt_nxt    = w_head_tim;
          w_v_re_nxt  = !w_pick_n;
          w_n_re_nxt  = w_pick_n;
          w_rr_nxt    = w_rr_adv;
          // Zero-time customers are popped and counted but never loaded
          if (w_head_tim != '0) begin
            w_ld_nxt = w_ld_sel;
          end else begin
            w_drop_nxt = drop_cnt + 8'd1;
          end
          // Age counts VIP wins that bypassed a waiting normal customer
          if (w_pick_n || n_emp) begin
            w_age_nxt = 4'd0;
          end else begin
            w_age_nxt = w_age_inc;
          end
        end
      end
      ST_LOAD:   w_state_nxt = ST_SETTLE;
      ST_SETTLE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and round-robin pointer; reset cancels any pulse in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_re     <= 1'b0;
      n_re     <= 1'b0;
      ld       <= '0;
      dn       <= '0;
      dt       <= '0;
      src      <= 1'b0;
      age      <= 4'd0;
      drop_cnt <= 8'd0;
      r_rr_ptr <= '0;
    end else begin
      v_re     <= w_v_re_nxt;
      n_re     <= w_n_re_nxt;
      ld       <= w_ld_nxt;
      dn       <= w_dn_nxt;
      dt       <= w_dt_nxt;
      src      <= w_src_nxt;
      age      <= w_age_nxt;
      drop_cnt <= w_drop_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_svc_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_svc_scheduler                                                |
// | Purpose  : Self-checking bench for svc_scheduler: vector table, directed   |
// |            corner sequences and a randomized FIFO/counter environment.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_svc_scheduler;

  localparam int DT_SZ   = 4;
  localparam int CNTER   = 3;
  localparam int AGE_MAX = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             v_emp = 1'b1;
  logic [DT_SZ-1:0] v_num = '0;
  logic [DT_SZ-1:0] v_tim = '0;
  logic             v_re;
  logic             n_emp = 1'b1;
  logic [DT_SZ-1:0] n_num = '0;
  logic [DT_SZ-1:0] n_tim = '0;
  logic             n_re;
  logic [CNTER-1:0] busy = '0;
  logic [CNTER-1:0] ld;
  logic [DT_SZ-1:0] dn;
  logic [DT_SZ-1:0] dt;
  logic             src;
  logic [3:0]       age;
  logic [7:0]       drop_cnt;

  svc_scheduler #(.DT_SZ(DT_SZ), .CNTER(CNTER), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rst(rst), .en(en),
    .v_emp(v_emp), .v_num(v_num), .v_tim(v_tim), .v_re(v_re),
    .n_emp(n_emp), .n_num(n_num), .n_tim(n_tim), .n_re(n_re),
    .busy(busy), .ld(ld), .dn(dn), .dt(dt), .src(src), .age(age),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Output bundle: {v_re, n_re, ld[2:0], dn, dt, src, age, drop_cnt} = 26 bits
  function automatic logic [25:0] outs();
    return {v_re, n_re, ld, dn, dt, src, age, drop_cnt};
  endfunction

  function automatic logic [25:0] mk(input logic vre, input logic nre, input logic [2:0] l,
                                     input logic [3:0] num, input logic [3:0] tim,
                                     input logic s, input logic [3:0] a, input logic [7:0] d);
    return {vre, nre, l, num, tim, s, a, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic e, input logic ve, input logic [3:0] vn, input logic [3:0] vt,
                        input logic ne, input logic [3:0] nn, input logic [3:0] nt,
                        input logic [2:0] b);
    en = e; v_emp = ve; v_num = vn; v_tim = vt;
    n_emp = ne; n_num = nn; n_tim = nt; busy = b;
  endtask

  // Assert reset now, release it 1 time unit after the next rising edge
  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic       en;
    logic       ve;
    logic [3:0] vn, vt;
    logic       ne;
    logic [3:0] nn, nt;
    logic [2:0] busy;
    logic       e_vre, e_nre;
    logic [2:0] e_ld;
    logic [3:0] e_dn, e_dt;
    logic       e_src;
    logic [3:0] e_age;
    logic [7:0] e_drop;
  } vec_t;

  typedef struct packed {
    logic [3:0] num;
    logic [3:0] tim;
  } ent_t;

  vec_t vecs[13];

  // Random-environment state
  ent_t        vq[$];
  ent_t        nq[$];
  int          rem[CNTER];
  logic        prev_vre, prev_nre;
  logic [2:0]  prev_ld;
  logic [3:0]  prev_dt;
  logic [2:0]  busyv;
  // Reference model state
  int          m_age, m_rr, m_drop, next_ok, k;
  logic [3:0]  m_dn, m_dt;
  logic        m_src, pend, pend_vre, pend_nre, pick_n;
  logic [2:0]  pend_ld;
  ent_t        head;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] e_src_a[8];
    logic [3:0] e_age_a[8];
    logic [2:0] e_ld_a[8];
    // en ve vn vt ne nn nt busy | vre nre ld dn dt src age drop
    vecs[0]  = '{1'b1, 1'b0, 4'd1, 4'd5, 1'b1, 4'd0, 4'd0, 3'b000, 1'b1, 1'b0, 3'b001, 4'd1, 4'd5, 1'b1, 4'd0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 4'd2, 4'd3, 3'b000, 1'b0, 1'b1, 3'b001, 4'd2, 4'd3, 1'b0, 4'd0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 4'd7, 4'd9, 1'b0, 4'd4, 4'd4, 3'b101, 1'b1, 1'b0, 3'b010, 4'd7, 4'd9, 1'b1, 4'd1, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 4'd3, 4'd6, 1'b1, 4'd0, 4'd0, 3'b001, 1'b1, 1'b0, 3'b010, 4'd3, 4'd6, 1'b1, 4'd0, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 4'd3, 4'd6, 1'b1, 4'd0, 4'd0, 3'b011, 1'b1, 1'b0, 3'b100, 4'd3, 4'd6, 1'b1, 4'd0, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 4'd3, 4'd6, 1'b1, 4'd0, 4'd0, 3'b110, 1'b1, 1'b0, 3'b001, 4'd3, 4'd6, 1'b1, 4'd0, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd4, 4'd0, 3'b000, 1'b0, 1'b1, 3'b000, 4'd4, 4'd0, 1'b0, 4'd0, 8'd1};
    vecs[7]  = '{1'b1, 1'b0, 4'd5, 4'd5, 1'b0, 4'd6, 4'd6, 3'b111, 1'b0, 1'b0, 3'b000, 4'd0, 4'd0, 1'b0, 4'd0, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 4'd5, 4'd5, 1'b1, 4'd6, 4'd6, 3'b000, 1'b0, 1'b0, 3'b000, 4'd0, 4'd0, 1'b0, 4'd0, 8'd0};
    vecs[9]  = '{1'b0, 1'b0, 4'd5, 4'd5, 1'b1, 4'd6, 4'd6, 3'b000, 1'b0, 1'b0, 3'b000, 4'd0, 4'd0, 1'b0, 4'd0, 8'd0};
    vecs[10] = '{1'b1, 1'b0, 4'd15, 4'd15, 1'b0, 4'd14, 4'd1, 3'b100, 1'b1, 1'b0, 3'b001, 4'd15, 4'd15, 1'b1, 4'd1, 8'd0};
    vecs[11] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 3'b000, 1'b1, 1'b0, 3'b000, 4'd0, 4'd0, 1'b1, 4'd0, 8'd1};
    vecs[12] = '{1'b1, 1'b0, 4'd8, 4'd2, 1'b0, 4'd3, 4'd3, 3'b010, 1'b1, 1'b0, 3'b001, 4'd8, 4'd2, 1'b1, 4'd1, 8'd0};

    // Reset state
    @(posedge clk); #1;
    check("reset_state", 32'(outs()), 32'(mk(0, 0, 3'b000, 4'd0, 4'd0, 0, 4'd0, 8'd0)));

    // Table: one dispatch from a freshly reset scheduler, checked in the LOAD cycle
    for (int i = 0; i < 13; i++) begin
      rst = 1'b1;
      set_in(vecs[i].en, vecs[i].ve, vecs[i].vn, vecs[i].vt,
             vecs[i].ne, vecs[i].nn, vecs[i].nt, vecs[i].busy);
      rst_pulse();
      @(posedge clk); #1;
      check($sformatf("table[%0d]", i), 32'(outs()),
            32'(mk(vecs[i].e_vre, vecs[i].e_nre, vecs[i].e_ld, vecs[i].e_dn, vecs[i].e_dt,
                   vecs[i].e_src, vecs[i].e_age, vecs[i].e_drop)));
    end

    // Aging: both FIFOs always non-empty -> V,V,V,N repeating, ld rotating
    e_src_a = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0};
    e_age_a = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    e_ld_a  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    rst = 1'b1;
    set_in(1, 0, 4'd1, 4'd1, 0, 4'd2, 4'd2, 3'b000);
    rst_pulse();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) @(posedge clk);
      else repeat (3) @(posedge clk);
      #1;
      check($sformatf("aging[%0d]", i), {21'd0, src, v_re, n_re, age, ld},
            {21'd0, e_src_a[i][0], e_src_a[i][0], !e_src_a[i][0], e_age_a[i], e_ld_a[i]});
    end

    // All counters busy: nothing moves for 20 cycles, then counter 2 frees up
    rst = 1'b1;
    set_in(1, 0, 4'd5, 4'd5, 0, 4'd6, 4'd6, 3'b111);
    rst_pulse();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("all_busy_hold", {27'd0, v_re, n_re, ld}, 32'd0);
    end
    busy = 3'b011;
    @(posedge clk); #1;
    check("busy_release", {14'd0, v_re, n_re, ld, dn, dt, age}, {14'd0, 1'b1, 1'b0, 3'b100, 4'd5, 4'd5, 4'd1});

    // Zero-time drops: 256 of them wrap drop_cnt back to 0
    rst = 1'b1;
    set_in(1, 1, 4'd0, 4'd0, 0, 4'd4, 4'd0, 3'b000);
    rst_pulse();
    for (int i = 1; i <= 256; i++) begin
      if (i == 1) @(posedge clk);
      else repeat (3) @(posedge clk);
      #1;
      check("drop_pop", {27'd0, v_re, n_re, ld}, {27'd0, 1'b0, 1'b1, 3'b000});
      if (i == 1)   check("drop_cnt_1",   32'(drop_cnt), 32'd1);
      if (i == 255) check("drop_cnt_255", 32'(drop_cnt), 32'd255);
      if (i == 256) check("drop_cnt_wrap", 32'(drop_cnt), 32'd0);
    end

    // Reset in the middle of LOAD cancels the pulse; the same head is redispatched
    rst = 1'b1;
    set_in(1, 0, 4'd5, 4'd2, 1, 4'd0, 4'd0, 3'b101);
    rst_pulse();
    @(posedge clk); #1;
    check("mid_load_pre", {20'd0, v_re, ld, dn, dt}, {20'd0, 1'b1, 3'b010, 4'd5, 4'd2});
    #1 rst = 1'b1;
    #1;
    check("mid_load_rst", 32'(outs()), 32'(mk(0, 0, 3'b000, 4'd0, 4'd0, 0, 4'd0, 8'd0)));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_load_redo", {20'd0, v_re, ld, dn, dt}, {20'd0, 1'b1, 3'b010, 4'd5, 4'd2});

    // en dropped during SETTLE: no further traffic until it returns
    rst = 1'b1;
    set_in(1, 0, 4'd1, 4'd5, 1, 4'd0, 4'd0, 3'b000);
    rst_pulse();
    @(posedge clk); #1;
    check("en_load", {27'd0, v_re, n_re, ld}, {27'd0, 1'b1, 1'b0, 3'b001});
    @(posedge clk); #1;
    en = 1'b0;
    check("en_settle", {27'd0, v_re, n_re, ld}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("en_low_hold", {27'd0, v_re, n_re, ld}, 32'd0);
    end
    en = 1'b1;
    @(posedge clk); #1;
    check("en_resume", {19'd0, v_re, n_re, ld, dn, dt}, {19'd0, 1'b1, 1'b0, 3'b010, 4'd1, 4'd5});

    // Randomized traffic against a transaction-level reference model
    rst = 1'b1;
    set_in(1, 1, 4'd0, 4'd0, 1, 4'd0, 4'd0, 3'b000);
    vq.delete(); nq.delete();
    for (int i = 0; i < CNTER; i++) rem[i] = 0;
    prev_vre = 0; prev_nre = 0; prev_ld = '0; prev_dt = '0;
    m_age = 0; m_rr = 0; m_drop = 0; m_dn = '0; m_dt = '0; m_src = 0;
    next_ok = 0; pend = 0; pend_vre = 0; pend_nre = 0; pend_ld = '0;
    rst_pulse();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      // Effects of the cycle that just ended
      if (prev_vre && vq.size() > 0) void'(vq.pop_front());
      if (prev_nre && nq.size() > 0) void'(nq.pop_front());
      for (int i = 0; i < CNTER; i++) begin
        if (prev_ld[i]) rem[i] = int'(prev_dt);
        busyv[i] = (rem[i] > 0);
        if (rem[i] > 0) rem[i]--;
      end
      if ($urandom_range(0, 19) == 0) busyv[$urandom_range(0, CNTER-1)] = 1'b1;
      if ($urandom_range(0, 99) < 30 && vq.size() < 8)
        vq.push_back('{4'($urandom), ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 6))});
      if ($urandom_range(0, 99) < 35 && nq.size() < 8)
        nq.push_back('{4'($urandom), ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 6))});
      en    = ($urandom_range(0, 9) != 0);
      v_emp = (vq.size() == 0);
      n_emp = (nq.size() == 0);
      v_num = v_emp ? 4'($urandom) : vq[0].num;
      v_tim = v_emp ? 4'($urandom) : vq[0].tim;
      n_num = n_emp ? 4'($urandom) : nq[0].num;
      n_tim = n_emp ? 4'($urandom) : nq[0].tim;
      busy  = busyv;

      @(negedge clk);
      check("random", 32'(outs()),
            32'(mk(pend & pend_vre, pend & pend_nre, pend ? pend_ld : 3'b000,
                   m_dn, m_dt, m_src, 4'(m_age), 8'(m_drop))));
      prev_vre = v_re; prev_nre = n_re; prev_ld = ld; prev_dt = dt;

      // Model: a decision may be taken every third cycle at the earliest
      pend = 1'b0;
      if (c >= next_ok && en && busyv != 3'b111 && (vq.size() > 0 || nq.size() > 0)) begin
        pick_n = (vq.size() == 0) || (nq.size() > 0 && m_age >= AGE_MAX);
        head   = pick_n ? nq[0] : vq[0];
        k = -1;
        for (int j = 0; j < CNTER; j++) begin
          if (k < 0 && !busyv[(m_rr + j) % CNTER]) k = (m_rr + j) % CNTER;
        end
        pend     = 1'b1;
        pend_vre = !pick_n;
        pend_nre = pick_n;
        pend_ld  = (head.tim != 0) ? 3'(1 << k) : 3'b000;
        if (head.tim == 0) m_drop = (m_drop + 1) % 256;
        m_rr  = (k + 1) % CNTER;
        m_dn  = head.num;
        m_dt  = head.tim;
        m_src = !pick_n;
        if (pick_n || nq.size() == 0) m_age = 0;
        else m_age = (m_age >= 15) ? 15 : m_age + 1;
        next_ok = c + 3;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
